// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO sequencing controller for external multiplier and divider units
module muldiv_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    input  logic        abort,
    output logic        mult_start,
    output logic        div_start,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic        mult_done,
    input  logic        div_done,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MULT_RUN = 2'b01,
        DIV_RUN  = 2'b10
    } state_t;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [5:0] WDOG_LAST = 6'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [5:0]  wdog;
    logic        accept;
    logic        unit_done;
    logic [31:0] unit_hi;
    logic [31:0] unit_lo;
    logic        load_ops;
    logic        wdog_inc;
    logic [31:0] hi_next;
    logic [31:0] lo_next;
    logic        start_mult_next;
    logic        start_div_next;
    logic        done_next;
    logic        div0_next;
    logic        timeout_next;

    assign accept    = req_valid && (state == IDLE);
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Only the unit that is actually running may complete the operation.
    assign unit_done = (state == MULT_RUN) ? mult_done : div_done;
    assign unit_hi   = (state == MULT_RUN) ? mult_hi : div_hi;
    assign unit_lo   = (state == MULT_RUN) ? mult_lo : div_lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        load_ops        = 1'b0;
        wdog_inc        = 1'b0;
        hi_next         = hi;
        lo_next         = lo;
        start_mult_next = 1'b0;
        start_div_next  = 1'b0;
        done_next       = 1'b0;
        div0_next       = 1'b0;
        timeout_next    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (req_op)
                        OP_MULT: begin
                            load_ops        = 1'b1;
                            start_mult_next = 1'b1;
                            state_next      = MULT_RUN;
                        end
                        OP_DIV: begin
                            // A zero divisor never reaches the divider.
                            if (req_b != 32'd0) begin
                                load_ops       = 1'b1;
                                start_div_next = 1'b1;
                                state_next     = DIV_RUN;
                            end else begin
                                div0_next = 1'b1;
                            end
                        end
                        OP_MTHI: begin
                            hi_next   = req_a;
                            done_next = 1'b1;
                        end
                        default: begin
                            lo_next   = req_a;
                            done_next = 1'b1;
                        end
                    endcase
                end
            end
            MULT_RUN, DIV_RUN: begin
                // Flush wins over completion and over the watchdog.
                if (abort) begin
                    state_next = IDLE;
                end else if (unit_done) begin
                    hi_next    = unit_hi;
                    lo_next    = unit_lo;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (wdog == WDOG_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    wdog_inc = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a        <= 32'd0;
            op_b        <= 32'd0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            wdog        <= 6'd0;
            mult_start  <= 1'b0;
            div_start   <= 1'b0;
            done        <= 1'b0;
            div0        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            hi <= hi_next;
            lo <= lo_next;
            if (load_ops) begin
                op_a <= req_a;
                op_b <= req_b;
                wdog <= 6'd0;
            end else if (wdog_inc) begin
                wdog <= wdog + 6'd1;
            end
            mult_start  <= start_mult_next;
            div_start   <= start_div_next;
            done        <= done_next;
            div0        <= div0_next;
            timeout_err <= timeout_next;
        end
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, meaning max cycles in a run state before abandoning the operation (range 2..63).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  control unit presents an operation.
REQ-005 SHALL have port req_op  input  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
REQ-006 SHALL have port req_a / req_b  input  32 each  operands; MTHI/MTLO use req_a only.
REQ-007 SHALL have port req_ready  output  1  high only in IDLE; request accepted on an edge where req_valid && req_ready.
REQ-008 SHALL have port abort  input  1  pipeline flush; cancels a running operation.
REQ-009 SHALL have ports mult_start / div_start  output  1 each  one-cycle start pulses to the multiplier / divider.
REQ-010 SHALL have port op_a / op_b  output  32 each  latched operands driven to both units.
REQ-011 SHALL have ports mult_done / div_done  input  1 each  unit completion pulses.
REQ-012 SHALL have ports mult_hi, mult_lo, div_hi, div_lo  input  32 each  unit results, valid while the matching done is high.
REQ-013 SHALL have ports hi / lo  output  32 each  architectural HI/LO registers.
REQ-014 SHALL have ports busy, done, div0, timeout_err  output  1 each  status; done/div0/timeout_err are one-cycle pulses.

Function
REQ-015 SHALL implement states IDLE, MULT_RUN, DIV_RUN; busy = (state != IDLE); req_ready = (state == IDLE).
REQ-016 SHALL on accepted MULT latch req_a/req_b into op_a/op_b, go to MULT_RUN, and assert mult_start during exactly the first MULT_RUN cycle.
REQ-017 SHALL on accepted DIV with req_b != 0 latch operands, go to DIV_RUN, and assert div_start during exactly the first DIV_RUN cycle.
REQ-018 SHALL on accepted DIV with req_b == 0 stay in IDLE, issue no div_start, leave hi/lo unchanged, and pulse div0 in the following cycle.
REQ-019 SHALL on accepted MTHI/MTLO write req_a into hi/lo at that edge, stay in IDLE, and pulse done in the following cycle.
REQ-020 SHALL hold op_a/op_b stable for the whole run state.
REQ-021 SHALL keep a 6-bit watchdog cleared on run entry and incremented each run cycle.
REQ-022 SHALL in MULT_RUN on mult_done load hi<=mult_hi, lo<=mult_lo, return to IDLE, and pulse done the next cycle (hi/lo already updated when done is high); DIV_RUN likewise with div_done/div_hi/div_lo.
REQ-023 SHALL ignore the done input of the unit not being run, and ignore both done inputs in IDLE.
REQ-024 SHALL when watchdog reaches TIMEOUT-1 without the matching done return to IDLE with hi/lo unchanged and pulse timeout_err the next cycle.
REQ-025 SHALL on abort in a run state return to IDLE with no hi/lo write and no done pulse; abort takes priority over a simultaneous done or timeout; abort in IDLE is ignored and does not block acceptance.
REQ-026 SHALL accept a new request in the first IDLE cycle after completion (back-to-back allowed).
REQ-027 SHALL use a registered start pulse, giving minimum accept-to-done latency of 3 cycles (accept edge, start cycle, done sampled, done pulse).

Reset
REQ-028 SHALL on reset assertion immediately force state IDLE, hi=lo=0, op_a=op_b=0, watchdog=0, and all pulse outputs and busy to 0 (req_ready=1 after release).
REQ-029 SHALL on reset during a run abandon the operation with no write, regardless of unit done activity.

Verification
REQ-030 SHALL cover: MULT a=7,b=-3, unit returns hi=FFFFFFFF lo=FFFFFFEB after 33 cycles -> one mult_start, hi/lo updated, done one pulse, busy high throughout run.
REQ-031 SHALL cover: DIV a=100,b=0 -> no div_start, div0 pulse next cycle, hi/lo unchanged, req_ready stays 1.
REQ-032 SHALL cover: MTHI a=12345678 then MTLO a=9ABCDEF0 on consecutive cycles -> hi=12345678, lo=9ABCDEF0, two done pulses.
REQ-033 SHALL cover: DIV a=50,b=7 with unit never returning done, TIMEOUT=40 -> IDLE after 40 run cycles, timeout_err one pulse, hi/lo unchanged.
REQ-034 SHALL cover: MULT run with abort and mult_done in the same cycle -> IDLE, no write, no done; then reset asserted mid-DIV -> all outputs 0 immediately.
